// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks (seq_bin2bcd, seq_divider).
package seq_arith_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: values of 5 or more get +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock,
// with a one-deep request buffer so a start arriving mid-conversion is not lost.
module seq_bin2bcd
    import seq_arith_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             conv_start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             conv_busy,
    output logic             conv_ready,
    output logic [3:0]       bcd_hundreds,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             overrun
);

    localparam int DW = 4 * DIGITS;
    localparam int SW = DW + WIDTH;

    seq_state_t       state, state_next;
    logic [3:0]       cnt;
    logic [SW-1:0]    shreg;
    logic [SW-1:0]    shreg_next;
    logic [DW-1:0]    dig_adj;
    logic [DW-1:0]    bcd_q;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_data;
    logic             last_iter;
    logic             unused_carry;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (shreg[WIDTH + 4*d +: 4]),
            .digit_out (dig_adj[4*d +: 4])
        );
    end

    // The corrected top digit never carries out for in-range inputs, so its MSB is dropped.
    assign unused_carry = dig_adj[DW-1];
    assign shreg_next   = {dig_adj[DW-2:0], shreg[WIDTH-1:0], 1'b0};
    assign last_iter    = (cnt == 4'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (conv_start) state_next = SHIFT;
            SHIFT:   if (last_iter) state_next = DONE;
            DONE:    state_next = (conv_start || pend_valid) ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            shreg      <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            bcd_q      <= '0;
            overrun    <= 1'b0;
        end else begin
            state   <= state_next;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (conv_start) begin
                        shreg <= {{DW{1'b0}}, bin_in};
                        cnt   <= 4'd0;
                    end
                end
                SHIFT: begin
                    shreg <= shreg_next;
                    cnt   <= cnt + 4'd1;
                    if (last_iter)
                        bcd_q <= shreg_next[SW-1 -: DW];
                    if (conv_start) begin
                        if (!pend_valid) begin
                            pend_valid <= 1'b1;
                            pend_data  <= bin_in;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A fresh start wins; buffered data waits for the next DONE.
                    if (conv_start) begin
                        shreg <= {{DW{1'b0}}, bin_in};
                        cnt   <= 4'd0;
                    end else if (pend_valid) begin
                        shreg      <= {{DW{1'b0}}, pend_data};
                        cnt        <= 4'd0;
                        pend_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign conv_ready   = (state == DONE);
    assign conv_busy    = (state != IDLE) | pend_valid;
    assign bcd_ones     = bcd_q[3:0];
    assign bcd_tens     = bcd_q[7:4];
    assign bcd_hundreds = bcd_q[11:8];

endmodule

// File: doc/seq_bin2bcd.md
SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, binary input width; only 8 is required to be supported.
REQ-002 The block SHALL have parameter DIGITS, default 3, number of BCD output digits.
REQ-003 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port conv_start  input  1  request; sampled on each rising clk edge.
REQ-006 The block SHALL have port bin_in  input  WIDTH  binary value, e.g. divider quotient or remainder; sampled together with conv_start.
REQ-007 The block SHALL have port conv_busy  output  1  high while converting or while a request is pending.
REQ-008 The block SHALL have port conv_ready  output  1  one-cycle pulse marking a result valid on the bcd_* outputs.
REQ-009 The block SHALL have ports bcd_hundreds, bcd_tens, bcd_ones  output  4 each  registered BCD result digits.
REQ-010 The block SHALL have port overrun  output  1  one-cycle pulse when a request is dropped.

Function
REQ-011 The block SHALL convert bin_in to BCD by sequential double-dabble: per iteration, add 3 to each digit >= 5, then shift {digits, binary} left by 1.
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, with a 4-bit iteration counter.
REQ-013 In IDLE, conv_start=1 SHALL load bin_in into the shift register, clear all digits, zero the counter and enter SHIFT.
REQ-014 SHIFT SHALL perform exactly one iteration per clock and SHALL enter DONE on the edge that performs iteration WIDTH.
REQ-015 That final edge SHALL register the digits into bcd_*.
REQ-016 conv_ready SHALL equal (state==DONE), so it is high for exactly one cycle.
REQ-017 Latency: with start sampled at edge N, conv_ready SHALL be high in the cycle after edge N+WIDTH (9 edges for WIDTH=8).
REQ-018 bcd_* SHALL hold their value until the next DONE entry; they SHALL NOT change during SHIFT.
REQ-019 A one-deep pending buffer (pend_valid, pend_data) SHALL capture conv_start in SHIFT when pend_valid=0.
REQ-020 conv_start in SHIFT with pend_valid=1 SHALL drop the request and pulse overrun for one cycle; the existing pending data SHALL be kept.
REQ-021 In DONE, a direct conv_start SHALL take priority over pending data: it is loaded, and the pending data stays buffered.
REQ-022 In DONE without conv_start, pend_valid=1 SHALL load pend_data, clear pend_valid and enter SHIFT.
REQ-023 In DONE with neither a start nor pending data, the FSM SHALL enter IDLE.
REQ-024 Back-to-back results SHALL be separated by exactly WIDTH+1 cycles (DONE followed directly by SHIFT).
REQ-025 conv_busy SHALL be (state!=IDLE) | pend_valid, driven combinationally.
REQ-026 Inputs 0 and 2^WIDTH-1 SHALL give the exact result (0,0,0 and 2,5,5); no digit SHALL exceed 9.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, pend_valid 0, conv_ready 0, overrun 0, conv_busy 0 and bcd_* 0.
REQ-028 Reset asserted mid-conversion SHALL abort it with no conv_ready pulse.
REQ-029 The first start sampled after rst deasserts SHALL be processed normally.

Structure
REQ-030 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and default WIDTH/DIGITS SHALL live in the shared package seq_arith_pkg, also used by seq_divider.
REQ-031 The per-digit add-3 correction SHALL be the combinational sub-module bcd_digit_adj (4-bit in, 4-bit out), instantiated DIGITS times.
REQ-032 All other logic SHALL be in one clocked always block plus combinational next-state logic.

Verification
REQ-033 The bench SHALL cover this directed case: start with bin_in=255 -> conv_ready 9 edges later; digits 2,5,5; overrun 0.
REQ-034 The bench SHALL cover this directed case: bin_in=0, then bin_in=100 -> 0,0,0 then 1,0,0; conv_busy low after the second DONE.
REQ-035 The bench SHALL cover this directed case: start 37, start 64 two cycles later -> two conv_ready pulses 9 cycles apart with 0,3,7 then 0,6,4; no overrun.
REQ-036 The bench SHALL cover this directed case: three starts (10, 20, 30) within one conversion -> results 10 and 20; overrun pulses once when 30 is issued.
REQ-037 The bench SHALL cover this directed case: rst pulse 4 cycles into converting 199 -> no conv_ready, outputs 0, conv_busy 0; a new start of 199 then gives 1,9,9.
REQ-038 The bench SHALL cover this directed case: chained after seq_divider, 200/7 quotient 28 fed on div_ready -> 0,2,8, with the result compared against a $display reference model over 1000 random values.
